// File: rtl/fxp_pkg.sv
// Shared Q-format constants and helpers for the fixed-point reciprocal datapath.
// Optional build macro in the consumer: RECIP_REG_OUT_EN (registered outputs).
package fxp_pkg;
   localparam int FXP_M = 12;
   localparam int FXP_N = 12;
   localparam int FXP_W = FXP_M + FXP_N;
   localparam logic [FXP_W-1:0] FXP_MAXP = {1'b0, {(FXP_W-1){1'b1}}};
   // Internal Newton-Raphson fraction bits beyond W.
   localparam int FXP_GUARD = 6;

   function automatic logic [FXP_W-1:0] toFixed(input int value);
      return FXP_W'(value <<< FXP_N);
   endfunction

   function automatic logic [FXP_W:0] absWide(input logic [FXP_W-1:0] x);
      logic [FXP_W:0] ext;
      ext = {x[FXP_W-1], x};
      return x[FXP_W-1] ? (~ext) + (FXP_W+1)'(1) : ext;
   endfunction

   // Rounded num/17 scaled by 2^frac; used for the linear reciprocal seed.
   function automatic logic [63:0] seedConst(input int num, input int frac);
      return ((64'(num) << frac) + 64'd8) / 64'd17;
   endfunction
endpackage

// File: rtl/fxp_lzc.sv
// Leading-zero counter; an all-zero input returns WIDTH.
module fxp_lzc #(
   parameter int WIDTH = 25
) (
   input  logic [WIDTH-1:0]               value,
   output logic [$clog2(WIDTH+1)-1:0]     count
);
   localparam int CW = $clog2(WIDTH+1);

   // Scanning upward lets the highest set bit win without a found flag.
   always_comb begin
      count = CW'(WIDTH);
      for (int i = 0; i < WIDTH; i++) begin
         if (value[i]) count = CW'(WIDTH - 1 - i);
      end
   end
endmodule

// File: rtl/fxp_reciprocal.sv
// Signed Qm.n reciprocal: normalise, linear seed, two Newton-Raphson steps, denormalise.
// Build macro RECIP_REG_OUT_EN adds one registered output stage.
module fxp_reciprocal
   import fxp_pkg::*;
#(
   parameter int M = FXP_M,
   parameter int N = FXP_N
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [M+N-1:0]   i_data,
   input  logic             i_abs,
   output logic [M+N-1:0]   o_data,
   output logic             o_sat
);
   localparam int W   = M + N;
   localparam int F   = W + FXP_GUARD;
   localparam int YW  = F + 2;
   localparam int LZW = $clog2(W + 2);
   localparam logic [W-1:0]  MAXP    = {1'b0, {(W-1){1'b1}}};
   localparam logic [YW-1:0] TWO     = YW'(2) << F;
   localparam logic [YW-1:0] C48     = YW'(seedConst(48, F));
   localparam logic [YW-1:0] C32     = YW'(seedConst(32, F));
   localparam logic [7:0]    SH_BASE = 8'(F + 1);
   // Exact quotient overflows MAXP exactly when r <= 2^(N+1-M).
   localparam int SAT_EXP = N + 1 - M;
   localparam logic [W:0] SAT_LIM = (SAT_EXP >= 0) ?
      ((W+1)'(1) << ((SAT_EXP >= 0) ? SAT_EXP : 0)) : '0;

   function automatic logic [YW-1:0] nrStep(input logic [F-1:0] d, input logic [YW-1:0] y);
      logic [F+YW-1:0]  e;
      logic [YW-1:0]    t;
      logic [2*YW-1:0]  p;
      e = {{YW{1'b0}}, d} * {{F{1'b0}}, y};
      t = TWO - YW'(e >> F);
      p = {{YW{1'b0}}, y} * {{YW{1'b0}}, t};
      return YW'(p >> F);
   endfunction

   logic            negIn;
   logic [W:0]      rMag;
   logic [LZW-1:0]  lz;
   logic [W:0]      dNorm;
   logic [F-1:0]    dFrac;
   logic            isPow2;
   logic [F+YW-1:0] seedProd;
   logic [YW-1:0]   y0, y1, y2, yFin;
   logic [7:0]      shAmt;
   logic            sat;
   logic [W-1:0]    mag;
   logic [W-1:0]    resData;

   assign negIn = i_data[W-1];
   assign rMag  = negIn ? (~{i_data[W-1], i_data}) + (W+1)'(1) : {1'b0, i_data};

   fxp_lzc #(.WIDTH(W + 1)) uLzc (
      .value (rMag),
      .count (lz)
   );

   assign dNorm  = rMag << lz;
   assign dFrac  = {dNorm, {(F-W-1){1'b0}}};
   assign isPow2 = (dNorm == {1'b1, {W{1'b0}}});

   assign seedProd = {{F{1'b0}}, C32} * {{YW{1'b0}}, dFrac};
   assign y0       = C48 - YW'(seedProd >> F);
   assign y1       = nrStep(dFrac, y0);
   assign y2       = nrStep(dFrac, y1);

   // NR converges from below, so powers of two would truncate one LSB short.
   assign yFin  = isPow2 ? TWO : y2;
   assign shAmt = SH_BASE - 8'(lz);

   assign sat     = (rMag <= SAT_LIM);
   assign mag     = sat ? MAXP : W'(yFin >> shAmt);
   assign resData = (negIn && !i_abs) ? -mag : mag;

`ifdef RECIP_REG_OUT_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         o_data <= '0;
         o_sat  <= 1'b0;
      end else begin
         o_data <= resData;
         o_sat  <= sat;
      end
   end
`else
   logic unusedClkReset;
   assign unusedClkReset = clk ^ reset;
   assign o_data = resData;
   assign o_sat  = sat;
`endif
endmodule

// File: tb/tb_fxp_reciprocal.sv
// Directed and random checks of fxp_reciprocal against a floor(2^2N / r) model.
// Handles both the combinational build and the RECIP_REG_OUT_EN build.
module tb_fxp_reciprocal;
   import fxp_pkg::*;

   localparam int W = FXP_W;
   localparam longint ONE2N = 64'sd1 << (2 * FXP_N);
   localparam longint MAXPL = (64'sd1 <<< (W - 1)) - 1;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [W-1:0]  i_data = '0;
   logic          i_abs = 1'b0;
   logic [W-1:0]  o_data;
   logic          o_sat;

   int testsRun = 0;
   int testsFailed = 0;

   logic [W-1:0] expQ[$];
   logic         satQ[$];
   longint       tolQ[$];

   fxp_reciprocal dut (
      .clk    (clk),
      .reset  (reset),
      .i_data (i_data),
      .i_abs  (i_abs),
      .o_data (o_data),
      .o_sat  (o_sat)
   );

   always #5 clk = ~clk;

   task automatic driveOp(input logic [W-1:0] x, input logic a);
      @(negedge clk);
      i_data = x;
      i_abs  = a;
   endtask

   task automatic waitResult();
`ifdef RECIP_REG_OUT_EN
      @(posedge clk);
      #1;
`else
      #1;
`endif
   endtask

   task automatic pushExp(input logic [W-1:0] d, input logic s, input longint tol);
      expQ.push_back(d);
      satQ.push_back(s);
      tolQ.push_back(tol);
   endtask

   task automatic checkResult(input string tag);
      logic [W-1:0] eD;
      logic         eS;
      longint       tol, obs, expv, diff;
      if (expQ.size() == 0) begin
         testsRun++;
         testsFailed++;
         $error("FAIL %s: scoreboard empty", tag);
         return;
      end
      eD  = expQ.pop_front();
      eS  = satQ.pop_front();
      tol = tolQ.pop_front();
      obs  = longint'($signed(o_data));
      expv = longint'($signed(eD));
      diff = (obs > expv) ? obs - expv : expv - obs;
      testsRun++;
      assert (!$isunknown(o_data) && diff <= tol) else begin
         testsFailed++;
         $error("FAIL %s data: observed %h expected %h tol %0d (x=%h abs=%b)",
                tag, o_data, eD, tol, i_data, i_abs);
      end
      testsRun++;
      assert (o_sat === eS) else begin
         testsFailed++;
         $error("FAIL %s sat: observed %b expected %b (x=%h abs=%b)", tag, o_sat, eS, i_data, i_abs);
      end
   endtask

   task automatic runExact(input logic [W-1:0] x, input logic a, input logic [W-1:0] d,
                           input logic s, input string tag);
      driveOp(x, a);
      pushExp(d, s, 0);
      waitResult();
      checkResult(tag);
   endtask

   task automatic runTol(input logic [W-1:0] x, input logic a, input logic [W-1:0] d,
                         input longint tol, input string tag);
      driveOp(x, a);
      pushExp(d, 1'b0, tol);
      waitResult();
      checkResult(tag);
   endtask

   task automatic refModel(input logic [W-1:0] x, input logic a,
                           output logic [W-1:0] d, output logic s, output longint tol);
      longint xs, r, fq, m;
      logic   neg;
      xs  = longint'($signed(x));
      r   = (xs < 0) ? -xs : xs;
      neg = !a && (xs < 0);
      fq  = (r == 0) ? 0 : ONE2N / r;
      s   = (r == 0) || (fq > MAXPL);
      if (s) begin
         m   = MAXPL;
         tol = 0;
      end else begin
         m   = fq;
         tol = ((fq >> (FXP_N - 2)) > 2) ? (fq >> (FXP_N - 2)) : 2;
      end
      d = W'(neg ? -m : m);
   endtask

   task automatic runModel(input logic [W-1:0] x, input logic a, input string tag);
      logic [W-1:0] d;
      logic         s;
      longint       tol;
      refModel(x, a, d, s, tol);
      driveOp(x, a);
      pushExp(d, s, tol);
      waitResult();
      checkResult(tag);
   endtask

   initial begin
      logic [W-1:0] rx;
      int           v;

      // Reset asserted together with live data.
      driveOp(toFixed(2), 1'b0);
`ifdef RECIP_REG_OUT_EN
      pushExp('0, 1'b0, 0);
      waitResult();
      checkResult("reset_state");
`else
      pushExp(24'h000800, 1'b0, 0);
      waitResult();
      checkResult("reset_ignored");
`endif
      reset = 1'b0;

      runExact(24'h002000, 1'b0, 24'h000800, 1'b0, "two");
      runExact(24'h001000, 1'b0, 24'h001000, 1'b0, "one");
      runExact(24'hFFC000, 1'b1, 24'h000400, 1'b0, "neg4_abs");
      runExact(24'hFFC000, 1'b0, 24'hFFFC00, 1'b0, "neg4_sign");
      runExact(24'h000000, 1'b0, 24'h7FFFFF, 1'b1, "zero_sign");
      runExact(24'h000000, 1'b1, 24'h7FFFFF, 1'b1, "zero_abs");
      runExact(24'h000001, 1'b0, 24'h7FFFFF, 1'b1, "lsb1_sat");
      runExact(24'h000002, 1'b0, 24'h7FFFFF, 1'b1, "lsb2_sat");
      runModel(24'h000003, 1'b0, "lsb3_edge");
      runExact(24'hFFFFFF, 1'b0, 24'h800001, 1'b1, "negsat");
      runExact(24'hFFFFFF, 1'b1, 24'h7FFFFF, 1'b1, "negsat_abs");
      runExact(24'h800000, 1'b0, 24'hFFFFFE, 1'b0, "most_neg");
      runExact(24'h800000, 1'b1, 24'h000002, 1'b0, "most_neg_abs");
      runTol  (24'h000C00, 1'b0, 24'h001555, 2, "three_quarters");
      runExact(24'h000800, 1'b0, 24'h002000, 1'b0, "half");
      runExact(24'h004000, 1'b0, 24'h000400, 1'b0, "four");
      runExact(24'h400000, 1'b0, 24'h000004, 1'b0, "pow1024");
      runExact(24'h000004, 1'b0, 24'h400000, 1'b0, "lsb4");
      runExact(24'hFFFFFC, 1'b0, 24'hC00000, 1'b0, "neg_lsb4");
      runModel(24'h7FFFFF, 1'b0, "max_pos");
      runModel(24'hFFF000, 1'b0, "neg_one");

      // Reset mid-stream discards the value in flight.
      reset = 1'b1;
      driveOp(24'h000C00, 1'b0);
`ifdef RECIP_REG_OUT_EN
      pushExp('0, 1'b0, 0);
      waitResult();
      checkResult("reset_midstream");
`else
      pushExp(24'h001555, 1'b0, 2);
      waitResult();
      checkResult("reset_midstream_ignored");
`endif
      reset = 1'b0;
      runExact(24'h002000, 1'b0, 24'h000800, 1'b0, "after_reset");

      for (int i = 0; i < 40; i++) begin
         v  = $urandom_range(0, 24);
         rx = W'(v);
         if ($urandom_range(0, 1) == 1) rx = -rx;
         runModel(rx, 1'($urandom_range(0, 1)), "rand_small");
      end
      for (int i = 0; i < 300; i++) begin
         rx = W'($urandom_range(0, (1 << W) - 1));
         runModel(rx, 1'($urandom_range(0, 1)), "rand");
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end
endmodule
